// File: rtl/round_divider_arbiter.sv
// round_divider_arbiter
//   Round-robin arbiter in front of one shared rounding power-of-two divider.
//   One transaction is in flight at a time: IDLE grants and captures operands,
//   CALC computes the rounded, saturated quotient, and RESP presents it until
//   the consumer accepts it.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   req_valid     per-requester request valid
//   req_data      8-bit dividends, requester i at [8*i+7:8*i]
//   req_shift     4-bit shift counts, requester i at [4*i+3:4*i]
//   req_ready     one-hot accept strobe (combinational, IDLE only)
//   rsp_valid     result valid (state RESP)
//   rsp_ready     consumer accepts result
//   rsp_data      rounded quotient
//   rsp_id        index of the requester served
//   busy          high whenever the FSM is not IDLE
//   done_cnt      completed responses, wraps 0xFFFF -> 0
//   dbg_state     current FSM state encoding (IDLE=0, CALC=1, RESP=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The requester holds its operands stable while it waits; the
// response side holds rsp_data/rsp_id stable until rsp_ready is seen.
module round_divider_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [8*NREQ-1:0]          req_data,
    input  logic [4*NREQ-1:0]          req_shift,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [7:0]                 rsp_data,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       busy,
    output logic [15:0]                done_cnt,
    output logic [1:0]                 dbg_state
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [7:0]       op_d_q, op_d_d;
    logic [3:0]       op_n_q, op_n_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]      done_cnt_q, done_cnt_d;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     cand_wide;
    logic [IDW-1:0]   cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_wide   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_wide = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand_wide >= (IDW+1)'(NREQ)) begin
                cand_wide = cand_wide - (IDW+1)'(NREQ);
            end
            cand = cand_wide[IDW-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Operand mux for the winning requester.
    logic [7:0] sel_data;
    logic [3:0] sel_shift;

    always_comb begin
        sel_data  = '0;
        sel_shift = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_shift = req_shift[4*i +: 4];
            end
        end
    end

    // Rounded divide by 2^n: the last bit shifted out decides round-up.
    logic [7:0] quot_c;
    logic       round_c;
    logic [8:0] sum_c;
    logic [7:0] result_c;

    always_comb begin
        quot_c  = (op_n_q >= 4'd8) ? 8'd0 : (op_d_q >> op_n_q);
        round_c = 1'b0;
        if (op_n_q >= 4'd1 && op_n_q <= 4'd8) begin
            round_c = op_d_q[3'(op_n_q - 4'd1)];
        end
        sum_c    = {1'b0, quot_c} + {8'd0, round_c};
        result_c = sum_c[8] ? 8'hFF : sum_c[7:0];
    end

    // Next-state and outputs.
    logic [NREQ-1:0] ready_c;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        op_d_d     = op_d_q;
        op_n_d     = op_n_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        done_cnt_d = done_cnt_q;
        ready_c    = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    ready_c[grant_idx] = 1'b1;
                    grant_id_d         = grant_idx;
                    op_d_d             = sel_data;
                    op_n_d             = sel_shift;
                    rr_ptr_d           = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                    state_d            = S_CALC;
                end
            end
            S_CALC: begin
                rsp_data_d = result_c;
                rsp_id_d   = grant_id_q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            op_d_q     <= '0;
            op_n_q     <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            op_d_q     <= op_d_d;
            op_n_q     <= op_n_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Accept strobe is suppressed while reset is asserted.
    assign req_ready = rst ? '0 : ready_c;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);
    assign done_cnt  = done_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_round_divider_arbiter.sv
module tb_round_divider_arbiter;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [15:0] req_shift;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] done_cnt;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    round_divider_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_shift(req_shift),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .done_cnt(done_cnt), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [7:0] d, input logic [3:0] n);
        req_data[8*id +: 8]  = d;
        req_shift[4*id +: 4] = n;
        req_valid[id]        = 1'b1;
    endtask

    task automatic wait_grant(input logic [3:0] onehot, input string name);
        int t = 0;
        while (req_ready !== onehot && t < 12) begin
            step();
            t++;
        end
        checks++;
        if (req_ready !== onehot) begin
            errors++;
            $display("FAIL %s grant timeout: req_ready=%b expected %b", name, req_ready, onehot);
        end
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        req_valid = 4'b1111; req_data = '0; req_shift = '0;
        #3;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
        checks++; if (rsp_data !== 8'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp got data=%0d id=%0d exp 0/0", rsp_data, rsp_id); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        step();
        req_valid = 4'b0000;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        drive_req(2, 8'd46, 4'd2);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || dbg_state !== 2'd1) begin errors++; $display("FAIL single_calc got valid=%b busy=%b st=%0d exp 0/1/1", rsp_valid, busy, dbg_state); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd12 || rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp got v=%b d=%0d id=%0d exp 1/12/2", rsp_valid, rsp_data, rsp_id); end
        step();
        checks++; if (done_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL single_done got cnt=%0d busy=%b exp 1/0", done_cnt, busy); end
    endtask

    task automatic test_rounding();
        logic [7:0] d_t[6]   = '{8'd45, 8'd255, 8'd200, 8'd128, 8'd127, 8'd255};
        logic [3:0] n_t[6]   = '{4'd2,  4'd1,   4'd0,   4'd8,   4'd8,   4'd12};
        logic [7:0] exp_t[6] = '{8'd11, 8'd128, 8'd200, 8'd1,   8'd0,   8'd0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_req(1, d_t[i], n_t[i]);
            #1;
            wait_grant(4'b0010, "round");
            step();
            req_valid = 4'b0000;
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_t[i]) begin
                errors++;
                $display("FAIL round_%0d d=%0d n=%0d got v=%b q=%0d exp q=%0d", i, d_t[i], n_t[i], rsp_valid, rsp_data, exp_t[i]);
            end
            step();
        end
        checks++; if (done_cnt !== 16'd7) begin errors++; $display("FAIL round_done_cnt got=%0d exp=7", done_cnt); end
    endtask

    task automatic test_rotation();
        int         order[6]   = '{0, 1, 2, 3, 0, 1};
        logic [7:0] exp_rot[4] = '{8'd2, 8'd10, 8'd18, 8'd26};
        logic [3:0] oh;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) drive_req(i, 8'(16*i + 3), 4'd1);
        rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int g = 0; g < 6; g++) begin
            oh = 4'b0001 << order[g];
            checks++; if (req_ready !== oh) begin errors++; $display("FAIL rot_grant_%0d got=%b exp=%b", g, req_ready, oh); end
            step();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rot_calc_ready_%0d got=%b exp=0000", g, req_ready); end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[g]) || rsp_data !== exp_rot[order[g]]) begin
                errors++;
                $display("FAIL rot_rsp_%0d got v=%b id=%0d d=%0d exp id=%0d d=%0d", g, rsp_valid, rsp_id, rsp_data, order[g], exp_rot[order[g]]);
            end
            step();
        end
        req_valid = 4'b0000;
        checks++; if (done_cnt !== 16'd6) begin errors++; $display("FAIL rot_done_cnt got=%0d exp=6", done_cnt); end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        drive_req(1, 8'd100, 4'd3);
        #1;
        wait_grant(4'b0010, "stall");
        step();
        req_valid = 4'b0000;
        drive_req(3, 8'd7, 4'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'd13 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || done_cnt !== 16'd6) begin
                errors++;
                $display("FAIL stall_cycle_%0d got v=%b d=%0d id=%0d rdy=%b cnt=%0d exp 1/13/1/0000/6", k, rsp_valid, rsp_data, rsp_id, req_ready, done_cnt);
            end
        end
        rsp_ready = 1'b1;
        step();
        checks++; if (done_cnt !== 16'd7 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_complete got cnt=%0d v=%b exp 7/0", done_cnt, rsp_valid); end
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_next_grant got=%b exp=1000", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        checks++; if (rsp_data !== 8'd7 || rsp_id !== 2'd3) begin errors++; $display("FAIL stall_next_rsp got d=%0d id=%0d exp 7/3", rsp_data, rsp_id); end
        step();
        checks++; if (done_cnt !== 16'd8) begin errors++; $display("FAIL stall_once got cnt=%0d exp=8", done_cnt); end
    endtask

    task automatic test_reset_in_calc();
        drive_req(2, 8'd9, 4'd1);
        #1;
        wait_grant(4'b0100, "rst_calc");
        step();
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL rst_calc_state got=%0d exp=1", dbg_state); end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_calc_clear got v=%b busy=%b cnt=%0d rdy=%b exp 0/0/0/0000", rsp_valid, busy, done_cnt, req_ready);
        end
        req_valid = 4'b0000;
        drive_req(0, 8'd40, 4'd3);
        drive_req(3, 8'd1, 4'd0);
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_calc_no_rsp got v=%b exp=0", rsp_valid); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_calc_regrant got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'd5) begin errors++; $display("FAIL rst_calc_rsp got v=%b id=%0d d=%0d exp 1/0/5", rsp_valid, rsp_id, rsp_data); end
        step();
        checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL rst_calc_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_cnt[2] = '{16'hFFFF, 16'h0000};
        force dut.done_cnt_q = 16'hFFFE;
        #1;
        release dut.done_cnt_q;
        #1;
        checks++; if (done_cnt !== 16'hFFFE) begin errors++; $display("FAIL wrap_preset got=%h exp=fffe", done_cnt); end
        for (int i = 0; i < 2; i++) begin
            drive_req(1, 8'd1, 4'd0);
            #1;
            wait_grant(4'b0010, "wrap");
            step();
            req_valid = 4'b0000;
            step();
            step();
            checks++; if (done_cnt !== exp_cnt[i]) begin errors++; $display("FAIL wrap_%0d got=%h exp=%h", i, done_cnt, exp_cnt[i]); end
        end
    endtask

    // Sequence and report
    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_rotation();
        test_stall();
        test_reset_in_calc();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
